// File: rtl/alu_mult_seq_if.sv
// Requester-side bundle for alu_mult_seq: operand request handshake and product response handshake.
interface alu_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*WIDTH-1:0] resp_p;
  logic               resp_z;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_p, resp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_p, resp_z
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier sequencing an external combinational ALU; all state lives here.
// Optional macro ALU_MULT_SKIP_ZERO_EN skips the ADD step for zero multiplier bits.
module alu_mult_seq #(
  parameter int         WIDTH  = 8,
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SRL = 3'b011
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mult_seq_if.slave    req_if,
  output logic             busy_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_y_i,
  input  logic             alu_c_i
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    alu_op_o = OP_ADD;
    alu_a_o  = '0;
    alu_b_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          m_d    = req_if.req_a;
          p_lo_d = req_if.req_b;
          p_hi_d = '0;
          cy_d   = 1'b0;
          cnt_d  = '0;
`ifdef ALU_MULT_SKIP_ZERO_EN
          state_d = req_if.req_b[0] ? ADD : SHIFT;
`else
          state_d = ADD;
`endif
        end
      end
      ADD: begin
        alu_op_o = OP_ADD;
        alu_a_o  = p_hi_q;
        alu_b_o  = p_lo_q[0] ? m_q : '0;
        p_hi_d   = alu_y_i;
        cy_d     = alu_c_i;
        state_d  = SHIFT;
      end
      SHIFT: begin
        // The ADD carry re-enters at the top so the full 2*WIDTH product survives.
        alu_op_o = OP_SRL;
        alu_a_o  = p_hi_q;
        p_hi_d   = {cy_q, alu_y_i[WIDTH-2:0]};
        p_lo_d   = {alu_c_i, p_lo_q[WIDTH-1:1]};
        cy_d     = 1'b0;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
`ifdef ALU_MULT_SKIP_ZERO_EN
          state_d = p_lo_q[1] ? ADD : SHIFT;
`else
          state_d = ADD;
`endif
        end
      end
      DONE: begin
        if (req_if.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_if.req_ready  = (state_q == IDLE);
  assign req_if.resp_valid = (state_q == DONE);
  assign req_if.resp_p     = {p_hi_q, p_lo_q};
  assign req_if.resp_z     = ({p_hi_q, p_lo_q} == '0);
  assign busy_o            = (state_q == ADD) || (state_q == SHIFT);

endmodule
